// File: rtl/disp_vramfill.sv
// AXI3 write master that fills a VRAM rectangle with one solid colour.
// One 16-beat INCR burst of 64-bit data is in flight at a time.
module disp_vramfill #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               START,
  input  logic [28:0]                        BASEADDR,
  input  logic [5:0]                         HBLK,
  input  logic [10:0]                        VLINES,
  input  logic [15:0]                        STRIDE,
  input  logic [23:0]                        COLOR,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               ERR,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [3:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic [1:0]                         M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_WID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [0:0]                         M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY,
  output logic                               M_AXI_ARVALID,
  output logic                               M_AXI_RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_FIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [5:0]  hblk, blk;
  logic [10:0] vlines, line;
  logic [15:0] stride;
  logic [28:0] line_addr, burst_addr;
  logic [31:0] pix;
  logic [3:0]  beat;
  logic        err;
  logic        last_blk, last_line;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign last_blk   = (blk + 6'd1) == hblk;
  assign last_line  = (line + 11'd1) == vlines;
  assign burst_addr = line_addr + {16'b0, blk, 7'b0};

  always_comb begin
    state_nxt     = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    case (state)
      S_IDLE: if (START) state_nxt = (HBLK == '0 || VLINES == '0) ? S_FIN : S_AW;
      S_AW: begin
        M_AXI_AWVALID = 1'b1;
        BUSY          = 1'b1;
        if (M_AXI_AWREADY) state_nxt = S_W;
      end
      S_W: begin
        M_AXI_WVALID = 1'b1;
        BUSY         = 1'b1;
        if (M_AXI_WREADY && beat == 4'd15) state_nxt = S_B;
      end
      S_B: begin
        M_AXI_BREADY = 1'b1;
        BUSY         = 1'b1;
        if (M_AXI_BVALID) state_nxt = (last_blk && last_line) ? S_FIN : S_AW;
      end
      S_FIN: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hblk      <= '0;
      vlines    <= '0;
      stride    <= '0;
      line_addr <= '0;
      pix       <= '0;
      blk       <= '0;
      line      <= '0;
      beat      <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && START) begin
        hblk      <= HBLK;
        vlines    <= VLINES;
        stride    <= STRIDE & 16'hFF80;
        line_addr <= BASEADDR & 29'h1FFF_FF80;
        pix       <= {8'h00, COLOR};
        blk       <= '0;
        line      <= '0;
        beat      <= '0;
        err       <= 1'b0;
      end
      if (state == S_W && M_AXI_WREADY) beat <= beat + 4'd1;
      if (state == S_B && M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00) err <= 1'b1;
        if (last_blk) begin
          blk       <= '0;
          line      <= line + 11'd1;
          line_addr <= line_addr + {13'b0, stride};
        end else begin
          blk <= blk + 6'd1;
        end
      end
    end
  end

  assign ERR           = err;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = {3'b001, burst_addr};
  assign M_AXI_AWLEN   = 4'd15;
  assign M_AXI_AWSIZE  = 3'b011;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = '0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_WID     = '0;
  assign M_AXI_WDATA   = {pix, pix};
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (state == S_W) && (beat == 4'd15);
  assign M_AXI_WUSER   = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

endmodule

// File: tb/tb_disp_vramfill.sv
// Scoreboard bench for disp_vramfill: expected AW addresses and W data are queued
// at START and retired as the master issues handshakes.
module tb_disp_vramfill;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [28:0] baseaddr;
  logic [5:0]  hblk;
  logic [10:0] vlines;
  logic [15:0] stride;
  logic [23:0] color;
  logic        busy, done, err;
  logic [0:0]  awid, wid, wuser;
  logic [31:0] awaddr;
  logic [3:0]  awlen, awcache;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, rready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  always #5 aclk = ~aclk;

  disp_vramfill #(
    .C_M_AXI_THREAD_ID_WIDTH(1),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(64)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn), .START(start), .BASEADDR(baseaddr),
    .HBLK(hblk), .VLINES(vlines), .STRIDE(stride), .COLOR(color),
    .BUSY(busy), .DONE(done), .ERR(err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WID(wid), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WUSER(wuser), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARVALID(arvalid), .M_AXI_RREADY(rready)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] aw_q[$];
  logic [63:0] exp_wdata;
  int          exp_bursts, beats_seen, beat_in_burst, bursts_b, done_cnt;
  int          b_pending, b_idx, err_idx, b_delay;
  bit          stall, bhs, prev_bhs;
  bit          aw_stall_prev, w_stall_prev, w_prev_last;
  logic [31:0] aw_prev;
  logic [63:0] w_prev_data;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // AW/W ready generator
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    forever begin
      @(posedge aclk); #1;
      awready = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
      wready  = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
    end
  end

  // B responder: one response per completed burst, optional delay and error injection
  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(posedge aclk); #1;
      if (bvalid && bhs) begin
        bvalid = 1'b0;
        bhs    = 1'b0;
        b_pending--;
      end
      if (!bvalid && b_pending > 0) begin
        if (b_delay == 0) begin
          bvalid  = 1'b1;
          bresp   = (b_idx == err_idx) ? 2'b10 : 2'b00;
          b_idx++;
          b_delay = stall ? int'($urandom_range(0, 7)) : 0;
        end else begin
          b_delay--;
        end
      end
    end
  end

  // Monitor: handshakes are sampled on the falling edge before the rising edge that completes them
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_stall_prev = 1'b0;
        w_stall_prev  = 1'b0;
        prev_bhs      = 1'b0;
      end else begin
        if (aw_stall_prev) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
        if (w_stall_prev) begin
          check("w_hold", wdata, w_prev_data);
          check("wlast_hold", {wvalid, wlast}, {1'b1, w_prev_last});
        end
        aw_stall_prev = awvalid && !awready;
        aw_prev       = awaddr;
        w_stall_prev  = wvalid && !wready;
        w_prev_data   = wdata;
        w_prev_last   = wlast;
        if (awvalid && awready) begin
          check("aw_count", aw_q.size() > 0, 1);
          if (aw_q.size() > 0) begin
            e = aw_q.pop_front();
            check("awaddr", awaddr, e);
          end
          check("aw_attr", {awlen, awsize, awburst, awcache, awid, awlock, awprot},
                {4'hF, 3'b011, 2'b01, 4'b0011, 1'b0, 2'b00, 3'b000});
        end
        if (wvalid && wready) begin
          check("wdata", wdata, exp_wdata);
          check("wlast", wlast, beat_in_burst == 15);
          check("wstrb", {wstrb, wuser}, {8'hFF, 1'b0});
          beats_seen++;
          if (beat_in_burst == 15) begin
            beat_in_burst = 0;
            b_pending++;
          end else begin
            beat_in_burst++;
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_bursts > 0) begin
            check("done_lat", prev_bhs, 1);
            check("done_after_b", bursts_b, exp_bursts);
          end
        end
        prev_bhs = bvalid && bready;
        if (bvalid && bready) begin
          bhs = 1'b1;
          bursts_b++;
        end
      end
    end
  end

  task automatic run_job(input logic [28:0] base, input logic [5:0] hb, input logic [10:0] vl,
                         input logic [15:0] st, input logic [23:0] col, input int err_at,
                         input bit dup, input int abort_beat);
    logic [28:0] a;
    int          nb, cyc;
    bit          aborted;
    aw_q.delete();
    nb = int'(hb) * int'(vl);
    for (int l = 0; l < int'(vl); l++)
      for (int b = 0; b < int'(hb); b++) begin
        a = (base & 29'h1FFFFF80) + 29'(l) * {13'b0, st & 16'hFF80} + 29'(b * 128);
        aw_q.push_back({3'b001, a});
      end
    exp_wdata     = {8'h00, col, 8'h00, col};
    exp_bursts    = nb;
    beats_seen    = 0;
    beat_in_burst = 0;
    bursts_b      = 0;
    done_cnt      = 0;
    b_idx         = 0;
    b_pending     = 0;
    b_delay       = 0;
    err_idx       = err_at;
    @(posedge aclk); #1;
    start = 1'b1; baseaddr = base; hblk = hb; vlines = vl; stride = st; color = col;
    @(posedge aclk); #1;
    start = 1'b0;
    @(negedge aclk);
    check("err_clr", err, 0);
    if (nb == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_aw", awvalid, 0);
    end else begin
      check("busy", busy, 1);
    end
    cyc     = 0;
    aborted = 1'b0;
    while (done_cnt == 0 && cyc < 20000 && !aborted) begin
      @(posedge aclk); #1;
      cyc++;
      if (dup && cyc == 10) begin
        start = 1'b1; hblk = 6'd5; color = ~col; baseaddr = 29'h1234_5000;
      end else if (dup && cyc == 11) begin
        start = 1'b0; hblk = hb; color = col; baseaddr = base;
      end
      if (abort_beat >= 0 && beats_seen == abort_beat) aborted = 1'b1;
    end
    if (aborted) begin
      aresetn = 1'b0;
      #1;
      check("rst_async", {awvalid, wvalid, bready, busy}, 4'b0000);
      aw_q.delete();
      b_pending = 0;
      bvalid    = 1'b0;
      bhs       = 1'b0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (4) @(posedge aclk);
      @(negedge aclk);
      check("rst_idle", {awvalid, wvalid, bready, busy, done, err}, 6'b0);
    end else begin
      check("timeout", cyc < 20000, 1);
      repeat (5) @(posedge aclk);
      @(negedge aclk);
      check("beats", beats_seen, nb * 16);
      check("aw_left", aw_q.size(), 0);
      check("done_cnt", done_cnt, 1);
      check("busy_end", busy, 0);
      check("err_end", err, (err_at >= 0 && err_at < nb) ? 1 : 0);
      check("ar_idle", {arvalid, rready}, 2'b00);
    end
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; baseaddr = '0; hblk = '0; vlines = '0; stride = '0; color = '0;
    stall = 1'b0; bhs = 1'b0; b_pending = 0; b_delay = 0; err_idx = -1; exp_bursts = 0;
    beats_seen = 0; beat_in_burst = 0; bursts_b = 0; done_cnt = 0; b_idx = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_out", {awvalid, wvalid, bready, busy, done, err}, 6'b0);
    #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);

    run_job(29'h100, 6'd1, 11'd1, 16'h0000, 24'h123456, -1, 1'b0, -1);
    run_job(29'h0,   6'd3, 11'd2, 16'h1000, 24'hA5C3F0, -1, 1'b0, -1);
    stall = 1'b1;
    run_job(29'h0,   6'd3, 11'd2, 16'h1000, 24'h0F1E2D, -1, 1'b0, -1);
    run_job(29'h0,   6'd3, 11'd2, 16'h1000, 24'h55AA33,  1, 1'b0, -1);
    stall = 1'b0;
    run_job(29'h40,  6'd2, 11'd0, 16'h1000, 24'h777777, -1, 1'b0, -1);
    run_job(29'h80,  6'd0, 11'd4, 16'h1000, 24'h888888, -1, 1'b0, -1);
    run_job(29'h0,   6'd3, 11'd2, 16'h1000, 24'hC0FFEE, -1, 1'b1, -1);
    run_job(29'h0,   6'd3, 11'd2, 16'h1000, 24'h010203, -1, 1'b0,  7);
    run_job(29'h37F, 6'd2, 11'd2, 16'h027F, 24'hFEDCBA, -1, 1'b0, -1);
    run_job(29'h1FFFFF80, 6'd2, 11'd1, 16'h0080, 24'h314159, -1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
